// File: rtl/poly_key_synth.sv
// Polyphonic PS/2 keyboard synth: scan-byte parser, voice allocator with oldest-voice stealing,
// per-voice square oscillators, popcount mixer and first-order delta-sigma speaker output.
module poly_key_synth #(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 20,
  localparam int LVL_W     = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_valid,
  input  logic [7:0]            scan_code,
  input  logic                  all_off,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [LVL_W-1:0]      mix_level,
  output logic                  voice_steal,
  output logic                  speaker
);

  localparam int               IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_VOICES - 1);
  localparam logic [LVL_W:0]   ACC_N   = (LVL_W + 1)'(NUM_VOICES);

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_e;

  function automatic logic [CNT_W-1:0] note_half_period(input logic [7:0] code);
    case (code)
      8'h15:        return CNT_W'(20'h5D2EF);
      8'h1D:        return CNT_W'(20'h530A8);
      8'h24:        return CNT_W'(20'h49FB6);
      8'h2D:        return CNT_W'(20'h45C12);
      8'h2C:        return CNT_W'(20'h3E47E);
      8'h35:        return CNT_W'(20'h377C8);
      8'h3C:        return CNT_W'(20'h316BD);
      8'h43, 8'h1C: return CNT_W'(20'h2EA85);
      8'h1B:        return CNT_W'(20'h29919);
      8'h23:        return CNT_W'(20'h25085);
      8'h2B:        return CNT_W'(20'h22F44);
      8'h34:        return CNT_W'(20'h1F23E);
      8'h33:        return CNT_W'(20'h1BBE4);
      8'h3B:        return CNT_W'(20'h18B76);
      8'h42, 8'h1A: return CNT_W'(20'h17544);
      8'h22:        return CNT_W'(20'h14CBA);
      8'h21:        return CNT_W'(20'h127ED);
      8'h2A:        return CNT_W'(20'h117D1);
      8'h32:        return CNT_W'(20'h0F91F);
      8'h31:        return CNT_W'(20'h0DDF2);
      8'h3A:        return CNT_W'(20'h0C5AF);
      8'h41:        return CNT_W'(20'h0BA8B);
      default:      return '0;
    endcase
  endfunction

  // ---------------- scan-byte parser ----------------
  state_e     state_q, state_d;
  logic       is_prefix, make_ev, brk_ev;
  logic       ev_make_q, ev_brk_q;
  logic [7:0] ev_code_q;

  assign is_prefix = (scan_code == 8'hF0) || (scan_code == 8'hE0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state_q <= ST_IDLE;
    else if (all_off) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (scan_valid) begin
      case (state_q)
        ST_IDLE:    if (scan_code == 8'hF0)      state_d = ST_BRK;
                    else if (scan_code == 8'hE0) state_d = ST_EXT;
        ST_BRK:     if (!is_prefix)              state_d = ST_IDLE;
        ST_EXT:     state_d = (scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    if (scan_valid && !all_off) begin
      case (state_q)
        ST_IDLE: make_ev = !is_prefix;
        ST_BRK:  brk_ev  = !is_prefix;
        default: ;
      endcase
    end
  end

  // The decoded event is registered; the voice bank acts on it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_make_q <= 1'b0;
      ev_brk_q  <= 1'b0;
      ev_code_q <= '0;
    end else begin
      ev_make_q <= make_ev;
      ev_brk_q  <= brk_ev;
      ev_code_q <= scan_code;
    end
  end

  // ---------------- voice bank ----------------
  logic [NUM_VOICES-1:0] act_q, act_d, sq_q, sq_d, hit;
  logic [7:0]            code_q [NUM_VOICES];
  logic [7:0]            code_d [NUM_VOICES];
  logic [CNT_W-1:0]      cnt_q  [NUM_VOICES];
  logic [CNT_W-1:0]      cnt_d  [NUM_VOICES];
  logic [CNT_W-1:0]      voice_hp [NUM_VOICES];
  logic [IDX_W-1:0]      age_q  [NUM_VOICES];
  logic [IDX_W-1:0]      age_d  [NUM_VOICES];
  logic [IDX_W-1:0]      free_idx, steal_idx, best_age, alloc_idx;
  logic                  held, found_free, do_alloc, steal;

  always_comb begin
    held       = 1'b0;
    hit        = '0;
    found_free = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    best_age   = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_hp[i] = note_half_period(code_q[i]);
      if (act_q[i] && code_q[i] == ev_code_q) begin
        hit[i] = 1'b1;
        held   = 1'b1;
      end
      if (age_q[i] > best_age) begin
        best_age  = age_q[i];
        steal_idx = IDX_W'(i);
      end
    end
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        found_free = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    do_alloc  = ev_make_q && (note_half_period(ev_code_q) != '0) && !held;
    alloc_idx = found_free ? free_idx : steal_idx;
    steal     = do_alloc && !found_free && !all_off;
  end

  always_comb begin
    act_d  = act_q;
    sq_d   = sq_q;
    code_d = code_q;
    cnt_d  = cnt_q;
    age_d  = age_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (act_q[i]) begin
        if (cnt_q[i] == voice_hp[i] - CNT_W'(1)) begin
          cnt_d[i] = '0;
          sq_d[i]  = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      if (do_alloc) begin
        if (IDX_W'(i) == alloc_idx) begin
          act_d[i]  = 1'b1;
          code_d[i] = ev_code_q;
          cnt_d[i]  = '0;
          sq_d[i]   = 1'b0;
          age_d[i]  = '0;
        end else if (act_q[i] && age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + IDX_W'(1);
        end
      end
      if (ev_brk_q && hit[i]) begin
        act_d[i] = 1'b0;
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end
    end
    if (all_off) begin
      act_d = '0;
      sq_d  = '0;
      cnt_d = '{default: '0};
      age_d = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the voice arrays are small flop banks, not RAM, so resetting them costs nothing extra.
      act_q  <= '0;
      sq_q   <= '0;
      code_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      age_q  <= '{default: '0};
    end else begin
      act_q  <= act_d;
      sq_q   <= sq_d;
      code_q <= code_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  // ---------------- mixer and delta-sigma ----------------
  logic [LVL_W-1:0] pop, mix_q;
  logic [LVL_W:0]   acc_q, acc_d, acc_sum;
  logic             spk_q, spk_d, steal_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) pop = pop + LVL_W'(act_q[i] & sq_q[i]);
    acc_sum = acc_q + {1'b0, mix_q};
    if (acc_sum >= ACC_N) begin
      acc_d = acc_sum - ACC_N;
      spk_d = 1'b1;
    end else begin
      acc_d = acc_sum;
      spk_d = 1'b0;
    end
    if (all_off) begin
      acc_d = '0;
      spk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_q   <= '0;
      acc_q   <= '0;
      spk_q   <= 1'b0;
      steal_q <= 1'b0;
    end else begin
      mix_q   <= all_off ? '0 : pop;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
      steal_q <= steal;
    end
  end

  assign voice_active = act_q;
  assign mix_level    = mix_q;
  assign voice_steal  = steal_q;
  assign speaker      = spk_q;

endmodule

// File: tb/tb_poly_key_synth.sv
// Self-checking bench for poly_key_synth (4 voices): directed scan sequences plus random bytes,
// compared every cycle against an event-level reference model of voices, mixer and modulator.
module tb_poly_key_synth;

  localparam int NV    = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scan_valid;
  logic [7:0]       scan_code;
  logic             all_off;
  logic [NV-1:0]    voice_active;
  logic [LVL_W-1:0] mix_level;
  logic             voice_steal;
  logic             speaker;

  poly_key_synth #(.NUM_VOICES(NV), .CNT_W(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .all_off      (all_off),
    .voice_active (voice_active),
    .mix_level    (mix_level),
    .voice_steal  (voice_steal),
    .speaker      (speaker)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int half_period(input logic [7:0] c);
    case (c)
      8'h15: return 'h5D2EF;  8'h1D: return 'h530A8;  8'h24: return 'h49FB6;
      8'h2D: return 'h45C12;  8'h2C: return 'h3E47E;  8'h35: return 'h377C8;
      8'h3C: return 'h316BD;  8'h43: return 'h2EA85;  8'h1C: return 'h2EA85;
      8'h1B: return 'h29919;  8'h23: return 'h25085;  8'h2B: return 'h22F44;
      8'h34: return 'h1F23E;  8'h33: return 'h1BBE4;  8'h3B: return 'h18B76;
      8'h42: return 'h17544;  8'h1A: return 'h17544;  8'h22: return 'h14CBA;
      8'h21: return 'h127ED;  8'h2A: return 'h117D1;  8'h32: return 'h0F91F;
      8'h31: return 'h0DDF2;  8'h3A: return 'h0C5AF;  8'h41: return 'h0BA8B;
      default: return 0;
    endcase
  endfunction

  // Reference model: voices remember the edge they were allocated on; a square's level is the
  // parity of elapsed half-periods, and the speaker fires whenever the running sum of levels
  // crosses another multiple of NV.
  int         edge_n = 0;
  bit         m_act   [NV];
  logic [7:0] m_code  [NV];
  int         m_alloc [NV];
  int         m_age   [NV];
  bit         seen_e0, seen_f0;
  bit         pend_v, pend_make;
  logic [7:0] pend_code;
  int         m_sum, m_mix;
  bit         m_spk, m_steal;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_code[i] = '0; m_alloc[i] = 0; m_age[i] = 0;
    end
    seen_e0 = 0; seen_f0 = 0; pend_v = 0; pend_make = 0; pend_code = '0;
    m_sum = 0; m_mix = 0; m_spk = 0; m_steal = 0;
  endtask

  task automatic apply_event(input int e);
    int tgt;
    if (pend_make) begin
      if (half_period(pend_code) == 0) return;
      for (int i = 0; i < NV; i++) if (m_act[i] && m_code[i] == pend_code) return;
      tgt = -1;
      for (int i = 0; i < NV; i++) if (!m_act[i] && tgt < 0) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[tgt]) tgt = i;
        m_steal = 1;
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_act[i] && m_age[i] < NV - 1) m_age[i]++;
      m_act[tgt] = 1; m_code[tgt] = pend_code; m_alloc[tgt] = e; m_age[tgt] = 0;
    end else begin
      for (int i = 0; i < NV; i++) if (m_act[i] && m_code[i] == pend_code) m_act[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    int new_mix;
    if (rst_n) begin
      edge_n++;
      new_mix = 0;
      for (int i = 0; i < NV; i++)
        if (m_act[i] && (((edge_n - 1 - m_alloc[i]) / half_period(m_code[i])) % 2 == 1))
          new_mix++;
      m_steal = 0;
      if (all_off) begin
        for (int i = 0; i < NV; i++) begin m_act[i] = 0; m_age[i] = 0; end
        seen_e0 = 0; seen_f0 = 0; pend_v = 0;
        m_sum = 0; m_mix = 0; m_spk = 0;
      end else begin
        m_spk = ((m_sum + m_mix) / NV) != (m_sum / NV);
        m_sum = m_sum + m_mix;
        m_mix = new_mix;
        if (pend_v) apply_event(edge_n);
        pend_v = 0;
        if (scan_valid) begin
          if (!seen_e0 && !seen_f0) begin
            if (scan_code == 8'hF0) seen_f0 = 1;
            else if (scan_code == 8'hE0) seen_e0 = 1;
            else begin pend_v = 1; pend_make = 1; pend_code = scan_code; end
          end else if (seen_f0 && !seen_e0) begin
            if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
              pend_v = 1; pend_make = 0; pend_code = scan_code; seen_f0 = 0;
            end
          end else if (seen_e0 && !seen_f0) begin
            if (scan_code == 8'hF0) seen_f0 = 1;
            else seen_e0 = 0;
          end else begin
            seen_e0 = 0; seen_f0 = 0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_outs();
    logic [NV-1:0] a;
    for (int i = 0; i < NV; i++) a[i] = m_act[i];
    return {23'd0, a, LVL_W'(m_mix), m_steal, m_spk};
  endfunction

  function automatic logic [31:0] dut_outs();
    return {23'd0, voice_active, mix_level, voice_steal, speaker};
  endfunction

  always @(negedge clk) if (rst_n && chk_en) check("outs", dut_outs(), exp_outs());

  task automatic send(input logic [7:0] b);
    @(negedge clk); scan_valid = 1'b1; scan_code = b;
    @(negedge clk); scan_valid = 1'b0;
  endtask

  task automatic expect_active(input string tag, input logic [NV-1:0] exp);
    @(posedge clk); #2;
    check(tag, 32'(voice_active), 32'(exp));
  endtask

  logic [7:0] pool [12] = '{8'h15, 8'h1D, 8'h24, 8'h33, 8'h43, 8'h1C, 8'h41,
                            8'h3A, 8'hF0, 8'hF0, 8'hE0, 8'h5A};

  initial begin
    rst_n = 1'b0; scan_valid = 1'b0; scan_code = '0; all_off = 1'b0;
    model_reset();
    #3 check("reset", dut_outs(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; chk_en = 1'b1;

    // Four short-period notes; wait until every square is high (level 4, speaker solid 1).
    send(8'h41); send(8'h3A); send(8'h31); send(8'h32);
    expect_active("four_held", 4'b1111);
    repeat (64000) @(negedge clk);
    check("mix_full", 32'(mix_level), 32'd4);
    check("spk_full", 32'(speaker), 32'd1);

    // Panic with a same-cycle byte: silenced, byte dropped.
    @(negedge clk); all_off = 1'b1; scan_valid = 1'b1; scan_code = 8'h15;
    @(negedge clk); all_off = 1'b0; scan_valid = 1'b0;
    check("panic_act", 32'(voice_active), 32'd0);
    check("panic_mix", 32'(mix_level), 32'd0);
    repeat (3) @(negedge clk);
    check("panic_drop", 32'(voice_active), 32'd0);

    send(8'h33);                           expect_active("make_33", 4'b0001);
    send(8'hF0); send(8'h33);              expect_active("break_33", 4'b0000);
    send(8'h15); send(8'h1D); send(8'h24); expect_active("three", 4'b0111);
    send(8'h1D);                           expect_active("repeat", 4'b0111);
    send(8'hF0); send(8'h1D);              expect_active("rel_1d", 4'b0101);
    send(8'h2D);                           expect_active("reuse_v1", 4'b0111);
    send(8'h33);                           expect_active("fill", 4'b1111);
    send(8'hE0); send(8'h33);              expect_active("ext_make", 4'b1111);
    send(8'hE0); send(8'hF0); send(8'h33); expect_active("ext_brk", 4'b1111);
    send(8'hF0); send(8'hF0); send(8'h33); expect_active("dbl_f0", 4'b0111);
    send(8'h5A);                           expect_active("unmapped", 4'b0111);
    send(8'h1C);                           expect_active("c4_a", 4'b1111);
    send(8'h43);
    @(posedge clk); #2;
    check("steal", 32'(voice_steal), 32'd1);
    check("steal_act", 32'(voice_active), 32'hF);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      scan_valid = ($urandom_range(0, 2) == 0);
      scan_code  = pool[$urandom_range(0, 11)];
      all_off    = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); scan_valid = 1'b0; all_off = 1'b0;

    // Asynchronous reset in the middle of a note.
    send(8'hF0); send(8'h41); send(8'h41);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_outs(), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hold", dut_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
